// File: rtl/down_counter_t_ff_pkg.sv
// Shared definitions for the T-flip-flop down-counter/timer: FSM encoding and default width.
package down_counter_t_ff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 3;

endpackage

// File: rtl/down_counter_t_ff_t_ff.sv
// Single T flip-flop cell: toggles on T_i, synchronous active-high clear.
module t_ff_cell (
    input  logic clk_i,
    input  logic reset_i,
    input  logic T_i,
    output logic Q_o
);

    logic q_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= 1'b0;
        end else if (T_i) begin
            q_q <= ~q_q;
        end
    end

    assign Q_o = q_q;

endmodule

// File: rtl/down_counter_t_ff.sv
// Programmable down-counter/timer on T-FF cells with one-shot and auto-reload modes.
// Handshake: load_i is a single-cycle strobe with no ready; it wins over en_i and is overridden only by reset_i.
module down_counter_t_ff
    import down_counter_t_ff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] Q_o,
    output logic             tc_o,
    output logic             uf_o,
    output logic             done_o,
    output logic             busy_o
);

    state_e           state_q;
    logic [WIDTH-1:0] reload_q;
    logic             mode_q;
    logic             uf_q;

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] toggle_d;
    logic [WIDTH:0]   borrow;
    logic             zero;
    logic             run_en;

    assign zero   = (count == '0);
    assign run_en = (state_q == ST_RUN) && en_i;

    // Bit i flips when every lower bit is 0: a decrement without a subtractor.
    always_comb begin
        borrow[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            borrow[i+1] = borrow[i] & ~count[i];
        end
    end

    always_comb begin
        toggle_d = '0;
        if (load_i) begin
            toggle_d = count ^ load_val_i;
        end else if (run_en) begin
            if (!zero) begin
                toggle_d = borrow[WIDTH-1:0];
            end else if (mode_q) begin
                toggle_d = count ^ reload_q;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        t_ff_cell u_cell (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .T_i     (toggle_d[g]),
            .Q_o     (count[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            reload_q <= '0;
            mode_q   <= 1'b0;
            uf_q     <= 1'b0;
        end else if (load_i) begin
            state_q  <= ST_RUN;
            reload_q <= load_val_i;
            mode_q   <= auto_reload_i;
            uf_q     <= 1'b0;
        end else begin
            uf_q <= 1'b0;
            if (run_en && zero) begin
                uf_q <= 1'b1;
                if (!mode_q) begin
                    state_q <= ST_DONE;
                end
            end
        end
    end

    assign Q_o    = count;
    assign tc_o   = zero;
    assign uf_o   = uf_q;
    assign done_o = (state_q == ST_DONE);
    assign busy_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_down_counter_t_ff.sv
// Directed plus randomized check of down_counter_t_ff against a behavioural timer model.
module tb_down_counter_t_ff;

    localparam int WIDTH = 3;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             en_i = 1'b0;
    logic             load_i = 1'b0;
    logic [WIDTH-1:0] load_val_i = '0;
    logic             auto_reload_i = 1'b0;
    logic [WIDTH-1:0] Q_o;
    logic             tc_o;
    logic             uf_o;
    logic             done_o;
    logic             busy_o;

    int checks = 0;
    int failures = 0;

    // Behavioural model state: 0 idle, 1 running, 2 expired.
    int m_q = 0;
    int m_reload = 0;
    int m_auto = 0;
    int m_phase = 0;
    int m_uf = 0;

    down_counter_t_ff #(.WIDTH(WIDTH)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .en_i          (en_i),
        .load_i        (load_i),
        .load_val_i    (load_val_i),
        .auto_reload_i (auto_reload_i),
        .Q_o           (Q_o),
        .tc_o          (tc_o),
        .uf_o          (uf_o),
        .done_o        (done_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int rst, input int en, input int ld, input int val, input int ar);
        if (rst != 0) begin
            m_q = 0; m_reload = 0; m_auto = 0; m_phase = 0; m_uf = 0;
        end else if (ld != 0) begin
            m_q = val; m_reload = val; m_auto = ar; m_phase = 1; m_uf = 0;
        end else if (m_phase == 1 && en != 0) begin
            if (m_q == 0) begin
                m_uf = 1;
                if (m_auto != 0) m_q = m_reload;
                else m_phase = 2;
            end else begin
                m_q = m_q - 1;
                m_uf = 0;
            end
        end else begin
            m_uf = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".q"}, int'(Q_o), m_q);
        check_val({tag, ".tc"}, int'(tc_o), (m_q == 0) ? 1 : 0);
        check_val({tag, ".uf"}, int'(uf_o), m_uf);
        check_val({tag, ".done"}, int'(done_o), (m_phase == 2) ? 1 : 0);
        check_val({tag, ".busy"}, int'(busy_o), (m_phase == 1) ? 1 : 0);
    endtask

    // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
    task automatic step(input string tag, input int rst, input int en, input int ld,
                        input int val, input int ar);
        reset_i       = (rst != 0);
        en_i          = (en != 0);
        load_i        = (ld != 0);
        load_val_i    = WIDTH'(val);
        auto_reload_i = (ar != 0);
        @(posedge clk_i);
        model_edge(rst, en, ld, val, ar);
        @(negedge clk_i);
        compare_all(tag);
    endtask

    initial begin
        int uf_seen;
        @(negedge clk_i);

        // 1: reset dominates load and enable
        step("rst0", 1, 1, 1, 5, 1);
        step("rst1", 1, 1, 1, 5, 1);
        check_val("rst.q_zero", int'(Q_o), 0);
        step("idle0", 0, 1, 0, 0, 0);
        step("idle1", 0, 1, 0, 0, 0);

        // 2: one-shot from 5 takes six enabled edges
        step("os_load", 0, 0, 1, 5, 0);
        for (int i = 0; i < 5; i++) step("os_cnt", 0, 1, 0, 0, 0);
        check_val("os.at_zero", int'(Q_o), 0);
        step("os_tc", 0, 1, 0, 0, 0);
        check_val("os.uf_pulse", int'(uf_o), 1);
        check_val("os.done", int'(done_o), 1);
        for (int i = 0; i < 3; i++) step("os_hold", 0, 1, 0, 0, 0);

        // 3: auto-reload from 2 gives one underflow every 3 enabled edges
        step("ar_load", 0, 0, 1, 2, 1);
        uf_seen = 0;
        for (int i = 0; i < 9; i++) begin
            step("ar_cnt", 0, 1, 0, 0, 0);
            uf_seen += int'(uf_o);
        end
        check_val("ar.uf_count", uf_seen, 3);

        // 4: gated enable
        step("gate_load", 0, 0, 1, 7, 0);
        for (int i = 0; i < 6; i++) step("gate_cnt", 0, (i % 2 == 0) ? 1 : 0, 0, 0, 0);
        check_val("gate.q", int'(Q_o), 4);

        // 5: load beats enable mid-count and at zero
        step("ld_a", 0, 0, 1, 5, 0);
        step("ld_b", 0, 1, 0, 0, 0);
        step("ld_c", 0, 1, 0, 0, 0);
        step("ld_mid", 0, 1, 1, 6, 0);
        check_val("ld_mid.q", int'(Q_o), 6);
        for (int i = 0; i < 6; i++) step("ld_run", 0, 1, 0, 0, 0);
        step("ld_zero", 0, 1, 1, 6, 0);
        check_val("ld_zero.uf", int'(uf_o), 0);

        // 6: reset with load in auto-reload loses reload value
        step("rl_load", 0, 0, 1, 4, 1);
        step("rl_rst", 1, 1, 1, 4, 1);
        for (int i = 0; i < 4; i++) step("rl_idle", 0, 1, 0, 0, 0);

        // 7: load 0 one-shot, first enabled edge is terminal; then auto-reload 0 pulses every edge
        step("z_load", 0, 1, 1, 0, 0);
        step("z_tc", 0, 1, 0, 0, 0);
        check_val("z.done", int'(done_o), 1);
        step("z_ar", 0, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) step("z_ar_cnt", 0, 1, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int rst, ld;
            rst = ($urandom_range(0, 99) < 2) ? 1 : 0;
            ld  = ($urandom_range(0, 99) < 8) ? 1 : 0;
            step("rand", rst, ($urandom_range(0, 3) != 0) ? 1 : 0, ld,
                 $urandom_range(0, MAXV), $urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/down_counter_t_ff.md
Name: down_counter_t_ff

Overview:
Programmable down-counter/timer built from T flip-flop cells. It is the counting-down counterpart of the team's T-FF up counter. Software or upstream logic loads a start value. The block decrements on each enabled clock and flags the terminal event. It then either stops (one-shot) or reloads (auto-reload). It sits beside the up counter as the timeout/period generator for the same datapath.

Parameters:
WIDTH, 3, counter width in bits (≥2).

Ports:
clk_i  input  1  clock; all state updates on rising edge.
reset_i  input  1  synchronous, active-high reset.
en_i  input  1  count enable; one decrement per clock while high in RUN.
load_i  input  1  load strobe; takes load_val_i and mode.
load_val_i  input  WIDTH  start/reload value.
auto_reload_i  input  1  mode, sampled only on load: 1 = auto-reload, 0 = one-shot.
Q_o  output  WIDTH  current count (registered).
tc_o  output  1  terminal count: combinational, high whenever Q_o == 0.
uf_o  output  1  registered one-cycle underflow pulse.
done_o  output  1  high while in DONE (one-shot expired).
busy_o  output  1  high while in RUN.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk_i and reset_i.
- Reset (reset_i high at an edge) overrides everything, including load_i.
- Reset values: Q_o=0, reload register=0, mode register=0, uf_o=0, state=IDLE. Hence done_o=0, busy_o=0, tc_o=1.
- States: IDLE, RUN, DONE.
- Load:
  - load_i high at an edge, in any state: Q_o←load_val_i, reload_reg←load_val_i, mode←auto_reload_i, state←RUN, uf_o←0.
  - load_i has priority over en_i in the same cycle; no decrement and no underflow that cycle.
- IDLE: Q_o holds; en_i ignored.
- RUN, en_i=1, Q_o≠0: Q_o←Q_o−1.
- RUN, en_i=1, Q_o==0: terminal event. uf_o←1 for exactly one cycle.
  - Auto-reload: Q_o←reload_reg, stay in RUN.
  - One-shot: Q_o stays 0, state←DONE.
- RUN, en_i=0: Q_o holds; uf_o←0.
- DONE: Q_o=0 held; en_i ignored; only load_i or reset_i leave DONE.
- Period: load value N gives exactly N+1 enabled clocks per terminal event.
- Load value 0: the first enabled clock is the terminal event. In auto-reload with N=0, uf_o pulses on every enabled clock.
- uf_o is cleared on every edge that is not a terminal event.
- Datapath uses WIDTH t_ff cells:
  - Decrement: bit i toggles when en and all lower bits are 0 (borrow chain).
  - Load/reload: T_i = Q ^ target value.
  - No arithmetic subtractor on the count path.
- Reset mid-operation: Q_o returns to 0 and the stored reload value is lost.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the default WIDTH.
- One sub-module: t_ff_cell.
  - Ports: clk_i, reset_i, T_i, Q_o.
  - Synchronous active-high reset to 0; Q toggles when T_i=1.
  - Instantiated WIDTH times via generate.
- FSM, toggle-vector generation and pulse logic stay in the top level.

Test Plan:
1. Hold reset_i for 2 cycles with en_i=1 and load_i=1 → Q_o=0, tc_o=1, uf_o=0, done_o=0, busy_o=0. Release with en_i=1 and no load → Q_o remains 0 (IDLE).
2. Load 5, one-shot, then en_i=1 continuously → Q_o sequence 5,4,3,2,1,0. On the 6th enabled edge after load: uf_o=1 for one cycle, done_o=1, busy_o=0. Further en_i keeps Q_o=0 with no further uf_o.
3. Load 2, auto-reload, en_i=1 → Q_o sequence 2,1,0,2,1,0,2. uf_o pulses exactly once per 3 clocks; busy_o stays 1.
4. Load 7, en_i alternating 1/0 → Q_o changes only after enabled edges: 7,6,6,5,5,4. tc_o stays low until Q_o=0.
5. In RUN at Q_o=3 with en_i=1, assert load_i with load_val_i=6 → next Q_o=6 (no decrement, no uf_o). Repeat at Q_o=0 → no uf_o pulse, Q_o=6.
6. Auto-reload at Q_o=4, then assert reset_i and load_i together → Q_o=0, IDLE. en_i=1 afterwards gives no count and no reload of 4.
7. Load 0, one-shot, en_i=1 → first enabled edge gives uf_o pulse and done_o=1.
